// File: rtl/wave_display_pipe.sv
// Waveform display pipeline.
// Turns a VGA pixel stream (x, y, valid) into a trace of samples held in a
// double-buffered waveform RAM. Each RAM sample covers 2^PIX_SHIFT columns of
// the plot region. The pixel coordinates are delayed to line up with the RAM
// read data, and the trace is drawn either as connected vertical spans
// (line mode) or as single dots (dot mode).
// Optional graticule: define WAVE_DISPLAY_GRID_EN to draw a 64-pixel grid;
// when it is undefined the grid output is tied low.
module wave_display_pipe #(
  parameter  int SAMPLE_W    = 8,
  parameter  int RAM_LATENCY = 1,
  parameter  int X_MIN       = 256,
  parameter  int X_SPAN_LOG2 = 9,
  parameter  int PIX_SHIFT   = 1,
  parameter  int Y_OFFSET    = 32,
  localparam int ADDR_W      = 1 + X_SPAN_LOG2 - PIX_SHIFT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         x,
  input  logic [9:0]          y,
  input  logic                valid,
  input  logic                read_index,
  input  logic                freeze,
  input  logic                mode,
  input  logic [SAMPLE_W-1:0] read_value,
  output logic [ADDR_W-1:0]   read_address,
  output logic                valid_pixel,
  output logic                display,
  output logic                grid,
  output logic                active_bank
);

  localparam int          COL_W   = ADDR_W - 1;
  localparam int          CMP_W   = (SAMPLE_W > 8) ? SAMPLE_W : 8;
  localparam logic [10:0] X_FIRST = 11'(X_MIN);
  localparam logic [11:0] X_LAST  = 12'(X_MIN + (1 << X_SPAN_LOG2) - 1);

  // Bank selection and address generation
  logic             bank_q;
  logic [10:0]      x_rel;
  logic [COL_W-1:0] col_idx;

  // Delay line aligning pixel coordinates with RAM data
  logic [10:0]       x_pipe    [RAM_LATENCY];
  logic [9:0]        y_pipe    [RAM_LATENCY];
  logic              valid_pipe[RAM_LATENCY];
  logic [ADDR_W-1:0] addr_pipe [RAM_LATENCY];

  logic [10:0]       x_d;
  logic [9:0]        y_d;
  logic              valid_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_d_last;

  // Sample scaling and trace comparison
  logic [SAMPLE_W-1:0] s;
  logic [SAMPLE_W-1:0] prev;
  logic [SAMPLE_W-1:0] prev_eff;
  logic                first_col;
  logic                col_changed;
  logic [CMP_W-1:0]    row_c;
  logic [CMP_W-1:0]    s_c;
  logic [CMP_W-1:0]    prev_c;
  logic [CMP_W-1:0]    span_lo;
  logic [CMP_W-1:0]    span_hi;
  logic                in_region;
  logic                hit;

  // Output registers
  logic valid_pixel_q;
  logic display_q;

  // Column index relative to the plot origin, truncated to one RAM half
  always_comb begin
    x_rel        = x - X_FIRST;
    col_idx      = COL_W'(x_rel >> PIX_SHIFT);
    read_address = {bank_q, col_idx};
  end

  // Bank register: only switches on the first visible pixel of a frame, and
  // never while freeze is held, so a frame is always drawn from one half
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= 1'b0;
    end else if (valid && (x == 11'd0) && (y == 10'd0) && !freeze) begin
      bank_q <= read_index;
    end
  end

  // Shift registers matching the RAM read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        x_pipe[i]     <= '0;
        y_pipe[i]     <= '0;
        valid_pipe[i] <= 1'b0;
        addr_pipe[i]  <= '0;
      end
    end else begin
      x_pipe[0]     <= x;
      y_pipe[0]     <= y;
      valid_pipe[0] <= valid;
      addr_pipe[0]  <= read_address;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        x_pipe[i]     <= x_pipe[i-1];
        y_pipe[i]     <= y_pipe[i-1];
        valid_pipe[i] <= valid_pipe[i-1];
        addr_pipe[i]  <= addr_pipe[i-1];
      end
    end
  end

  assign x_d     = x_pipe[RAM_LATENCY-1];
  assign y_d     = y_pipe[RAM_LATENCY-1];
  assign valid_d = valid_pipe[RAM_LATENCY-1];
  assign addr_d  = addr_pipe[RAM_LATENCY-1];

  // Scale the sample, detect column boundaries and decide whether this pixel
  // falls on the trace. On the first column of a line the previous-sample
  // register still holds the previous line's last value, so the current
  // sample is used in its place to avoid a spurious vertical streak.
  always_comb begin
    s           = (read_value >> 1) + SAMPLE_W'(Y_OFFSET);
    first_col   = valid_d && (x_d == X_FIRST);
    col_changed = (addr_d != addr_d_last);
    prev_eff    = first_col ? s : prev;

    row_c  = CMP_W'(y_d[8:1]);
    s_c    = CMP_W'(s);
    prev_c = CMP_W'(prev_eff);

    if (prev_c < s_c) begin
      span_lo = prev_c;
      span_hi = s_c;
    end else begin
      span_lo = s_c;
      span_hi = prev_c;
    end

    in_region = valid_d && (y_d < 10'd512) &&
                (x_d >= X_FIRST) && ({1'b0, x_d} <= X_LAST);

    if (mode) begin
      hit = (row_c == s_c);
    end else begin
      hit = (row_c >= span_lo) && (row_c <= span_hi);
    end
  end

  // Previous-column sample: captured whenever the aligned address moves on
  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= '0;
      addr_d_last <= '0;
    end else begin
      addr_d_last <= addr_d;
      if (col_changed || first_col) begin
        prev <= s;
      end
    end
  end

  // Registered pixel outputs, one cycle after alignment with RAM data
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_pixel_q <= 1'b0;
      display_q     <= 1'b0;
    end else begin
      valid_pixel_q <= in_region;
      display_q     <= hit && in_region;
    end
  end

  assign valid_pixel = valid_pixel_q;
  assign display     = display_q;
  assign active_bank = bank_q;

`ifdef WAVE_DISPLAY_GRID_EN
  logic [5:0] grid_x_off;
  logic       on_grid;
  logic       grid_q;

  // Graticule lines every 64 pixels, measured from the plot origin in x
  always_comb begin
    grid_x_off = x_d[5:0] - X_FIRST[5:0];
    on_grid    = (grid_x_off == 6'd0) || (y_d[5:0] == 6'd0);
  end

  // Graticule output register, same latency as the trace
  always_ff @(posedge clk) begin
    if (reset) begin
      grid_q <= 1'b0;
    end else begin
      grid_q <= in_region && on_grid;
    end
  end

  assign grid = grid_q;
`else
  assign grid = 1'b0;
`endif

endmodule
